// File: rtl/shift_pipe.sv
// Two-stage valid/ready barrel shifter: SHL, SHR, SAR and (with SHIFT_PIPE_ROTATE_EN) ROL.
// Without SHIFT_PIPE_ROTATE_EN, mode 2'b11 behaves exactly like SHL and no rotate logic is built.
module shift_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam int LO_W = SHW / 2;
  localparam int HI_W = SHW - LO_W;
  localparam int LW   = $clog2(WIDTH);

  localparam logic [1:0] MODE_SHL = 2'b00;
  localparam logic [1:0] MODE_SHR = 2'b01;
  localparam logic [1:0] MODE_SAR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

`ifdef SHIFT_PIPE_ROTATE_EN
  function automatic logic signed [WIDTH-1:0] rol_fn(input logic signed [WIDTH-1:0] x,
                                                     input logic [LW-1:0]            r);
    logic [2*WIDTH-1:0] t;
    t = {x, x} << r;
    return $signed(t[2*WIDTH-1:WIDTH]);
  endfunction
`endif

  function automatic logic signed [WIDTH-1:0] shift_fn(input logic signed [WIDTH-1:0] x,
                                                       input logic [SHW-1:0]          amt,
                                                       input logic [1:0]              mode);
    logic signed [WIDTH-1:0] r;
    case (mode)
      MODE_SHR: r = $signed($unsigned(x) >> amt);
      MODE_SAR: r = x >>> amt;
`ifdef SHIFT_PIPE_ROTATE_EN
      MODE_ROL: r = rol_fn(x, amt[LW-1:0]);
`endif
      default:  r = x << amt;
    endcase
    return r;
  endfunction

  // Amounts of WIDTH or more saturate; rotation is already modulo WIDTH.
  function automatic logic signed [WIDTH-1:0] range_fn(input logic signed [WIDTH-1:0] shifted,
                                                       input logic                    sign,
                                                       input logic                    over,
                                                       input logic [1:0]              mode);
    logic signed [WIDTH-1:0] r;
    r = shifted;
    if (over) begin
      case (mode)
        MODE_SAR: r = {WIDTH{sign}};
`ifdef SHIFT_PIPE_ROTATE_EN
        MODE_ROL: r = shifted;
`endif
        default:  r = '0;
      endcase
    end
    return r;
  endfunction

  logic                    vld_p1_q, vld_p1_d;
  logic signed [WIDTH-1:0] data_p1_q, data_p1_d;
  logic [1:0]              mode_p1_q, mode_p1_d;
  logic [HI_W-1:0]         shamt_hi_p1_q, shamt_hi_p1_d;
  logic                    over_p1_q, over_p1_d;

  logic                    vld_p2_q, vld_p2_d;
  logic signed [WIDTH-1:0] data_p2_q, data_p2_d;
  logic                    zero_p2_q, zero_p2_d;

  logic                    accept;
  logic                    out_load;
  logic [SHW-1:0]          lo_amt;
  logic [SHW-1:0]          hi_amt;
  logic signed [WIDTH-1:0] res_p2;

  always_comb begin
    in_ready = !vld_p1_q || !vld_p2_q || out_ready;
    out_load = !vld_p2_q || out_ready;
    accept   = in_valid && in_ready;

    // Stage 1: low amount bits; mode, upper amount bits and range flag ride along.
    lo_amt        = {{HI_W{1'b0}}, in_shamt[LO_W-1:0]};
    vld_p1_d      = accept || (vld_p1_q && !out_load);
    data_p1_d     = data_p1_q;
    mode_p1_d     = mode_p1_q;
    shamt_hi_p1_d = shamt_hi_p1_q;
    over_p1_d     = over_p1_q;
    if (accept) begin
      data_p1_d     = shift_fn($signed(in_data), lo_amt, in_mode);
      mode_p1_d     = in_mode;
      shamt_hi_p1_d = in_shamt[SHW-1:LO_W];
      over_p1_d     = |in_shamt[SHW-1:LW];
    end

    // Stage 2: upper amount bits, range handling, output register.
    hi_amt    = {shamt_hi_p1_q, {LO_W{1'b0}}};
    res_p2    = range_fn(shift_fn(data_p1_q, hi_amt, mode_p1_q),
                         data_p1_q[WIDTH-1], over_p1_q, mode_p1_q);
    vld_p2_d  = out_load ? vld_p1_q : vld_p2_q;
    data_p2_d = data_p2_q;
    zero_p2_d = zero_p2_q;
    if (out_load && vld_p1_q) begin
      data_p2_d = res_p2;
      zero_p2_d = (res_p2 == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      zero_p2_q <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      zero_p2_q <= zero_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    data_p1_q     <= data_p1_d;
    mode_p1_q     <= mode_p1_d;
    shamt_hi_p1_q <= shamt_hi_p1_d;
    over_p1_q     <= over_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign out_zero  = zero_p2_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: driver pushes model results on accept, monitor pops on output handshake.
module tb_shift_pipe;
  localparam int WIDTH = 32;
  localparam int SHW   = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  shift_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pushes = 0;
  int pops = 0;
  int last_acc = 0;
  logic [WIDTH-1:0] exp_q[$];
  int out_cyc_q[$];
  logic [WIDTH-1:0] last_out;
  logic last_zero;
  bit rand_done;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: apply the operation one bit position at a time.
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input int sh,
                                             input logic [1:0] m);
    logic [WIDTH-1:0] r;
    r = d;
    case (m)
      2'd0: for (int i = 0; i < sh; i++) r = {r[WIDTH-2:0], 1'b0};
      2'd1: for (int i = 0; i < sh; i++) r = {1'b0, r[WIDTH-1:1]};
      2'd2: for (int i = 0; i < sh; i++) r = {d[WIDTH-1], r[WIDTH-1:1]};
      default: begin
`ifdef SHIFT_PIPE_ROTATE_EN
        for (int i = 0; i < sh % WIDTH; i++) r = {r[WIDTH-2:0], r[WIDTH-1]};
`else
        for (int i = 0; i < sh; i++) r = {r[WIDTH-2:0], 1'b0};
`endif
      end
    endcase
    return r;
  endfunction

  logic             prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic             prev_zero;

  always @(negedge clk) begin
    logic [WIDTH-1:0] e;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, prev_data);
        check("hold_zero", 32'(out_zero), 32'(prev_zero));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got %h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("data", out_data, e);
          check("zero", 32'(out_zero), 32'(e == '0));
          pops++;
          out_cyc_q.push_back(cyc);
          last_out  = out_data;
          last_zero = out_zero;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_zero = out_zero;
    end
  end

  // Called just after a rising edge; returns just after the rising edge that took the operand.
  task automatic send(input logic [WIDTH-1:0] d, input logic [SHW-1:0] sh, input logic [1:0] m);
    bit done;
    done     = 1'b0;
    in_data  = d;
    in_shamt = sh;
    in_mode  = m;
    in_valid = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(d, int'(sh), m));
        pushes++;
        last_acc = cyc;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int a0;
    int p0;
    int acc_q[$];
    logic [WIDTH-1:0] rol1_exp;
    logic [WIDTH-1:0] rol33_exp;
`ifdef SHIFT_PIPE_ROTATE_EN
    rol1_exp  = 32'h00000003;
    rol33_exp = 32'h00000003;
`else
    rol1_exp  = 32'h00000002;
    rol33_exp = 32'h00000000;
`endif
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // SHL with latency
    out_ready = 1'b1;
    out_cyc_q.delete();
    send(32'h000000FF, 6'd4, 2'b00);
    a0 = last_acc;
    drain();
    check("shl_value", last_out, 32'h00000FF0);
    check("shl_zero", 32'(last_zero), 32'd0);
    check("shl_latency", 32'(out_cyc_q[0]), 32'(a0 + 2));

    // Over-range
    send(32'h80000000, 6'd31, 2'b10); drain();
    check("sar31", last_out, 32'hFFFFFFFF);
    send(32'h80000000, 6'd40, 2'b10); drain();
    check("sar40", last_out, 32'hFFFFFFFF);
    send(32'h80000000, 6'd40, 2'b01); drain();
    check("shr40", last_out, 32'h00000000);
    check("shr40_zero", 32'(last_zero), 32'd1);
    send(32'h12345678, 6'd0, 2'b10); drain();
    check("sar0_identity", last_out, 32'h12345678);

    // Rotate
    send(32'h80000001, 6'd1, 2'b11); drain();
    check("rol1", last_out, rol1_exp);
    send(32'h80000001, 6'd33, 2'b11); drain();
    check("rol33", last_out, rol33_exp);

    // Backpressure
    out_ready = 1'b0;
    p0 = pushes;
    a0 = pops;
    send(32'h00000011, 6'd1, 2'b00);
    send(32'h00000022, 6'd2, 2'b01);
    in_data = 32'h00000033; in_shamt = 6'd3; in_mode = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check("bp_accepted", 32'(pushes - p0), 32'd2);
    out_ready = 1'b1;
    send(32'h00000033, 6'd3, 2'b00);
    drain();
    check("bp_results", 32'(pops - a0), 32'd3);
    check("bp_last", last_out, 32'h00000198);

    // Reset mid-flight
    out_ready = 1'b0;
    send(32'hAAAA5555, 6'd4, 2'b00);
    send(32'h5555AAAA, 6'd4, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_data", out_data, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    p0 = pops;
    repeat (6) @(posedge clk);
    #1;
    check("flush_no_result", 32'(pops), 32'(p0));

    // Back-to-back streaming
    out_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      send($urandom, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));
      acc_q.push_back(last_acc);
    end
    drain();
    check("stream_count", 32'(out_cyc_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < out_cyc_q.size(); i++) begin
      check("stream_accept_cycle", 32'(acc_q[i]), 32'(acc_q[0] + i));
      check("stream_out_cycle", 32'(out_cyc_q[i]), 32'(acc_q[0] + 2 + i));
    end

    // Random traffic with random backpressure
    rand_done = 1'b0;
    p0 = pops;
    a0 = pushes;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send($urandom, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("rand_count", 32'(pops - p0), 32'(pushes - a0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width; power of two, minimum 8.
REQ-002 SHALL have parameter SHW, default 6: shift-amount width; 2^(SHW-1) >= WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: input operand valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept input this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits: operand, two's complement.
REQ-008 SHALL have port in_shamt, input, SHW bits: shift amount, unsigned, 0..2^SHW-1.
REQ-009 SHALL have port in_mode, input, 2 bits: operation select. 00 SHL, 01 SHR logical, 10 SAR arithmetic, 11 ROL.
REQ-010 SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-012 SHALL have port out_data, output, WIDTH bits: shifted result.
REQ-013 SHALL have port out_zero, output, 1 bit: out_data equals 0.

Function
REQ-014 SHALL accept input on a cycle where in_valid and in_ready are both 1, and SHALL produce result on a cycle where out_valid and out_ready are both 1.
REQ-015 SHALL implement a two-stage registered pipeline: stage 1 applies shift by in_shamt[SHW/2-1:0]; stage 2 applies the remaining bits plus over-range handling and drives out_data.
REQ-016 SHALL make a result visible on out_valid exactly 2 cycles after acceptance when not stalled; throughput 1 per cycle.
REQ-017 SHALL use in_ready = !s1_valid || !out_valid || out_ready; no combinational path from in_valid to in_ready.
REQ-018 SHALL, once out_valid is high, hold out_data and out_zero stable until the result is accepted.
REQ-019 SHALL preserve order and SHALL not drop or duplicate any transaction under any out_ready pattern.
REQ-020 SHL SHALL fill vacated bits with 0 and discard bits shifted out (no overflow trap).
REQ-021 SHR SHALL zero-fill; SAR SHALL replicate in_data[WIDTH-1].
REQ-022 SHALL handle in_shamt >= WIDTH as follows: SHL and SHR yield 0; SAR yields all sign bits; ROL uses in_shamt mod WIDTH.
REQ-023 SHALL return in_data unchanged for in_shamt = 0 in every mode.
REQ-024 SHALL carry mode and amount alongside data through stage 1; no input is sampled outside the accept cycle.

Reset
REQ-025 SHALL, while rst = 1, clear s1_valid, out_valid, out_data and out_zero to 0; out_zero reset value is 0.
REQ-026 SHALL drive in_ready to 1 from the first cycle after rst deasserts.
REQ-027 SHALL discard in-flight transactions on reset mid-operation; no stale result appears after release.

Configuration
REQ-028 SHALL compile mode 11 as rotate-left only when SHIFT_PIPE_ROTATE_EN is defined; bits leaving the MSB re-enter at the LSB.
REQ-029 SHALL, without SHIFT_PIPE_ROTATE_EN, treat mode 11 exactly as SHL (mode 00) and contain no rotate logic.

Verification
REQ-030 SHALL cover SHL: 0x000000FF, shamt 4 -> out_data 0x00000FF0, out_valid exactly 2 cycles after accept, out_zero 0.
REQ-031 SHALL cover over-range: SAR 0x80000000 shamt 31 -> 0xFFFFFFFF; SAR shamt 40 -> 0xFFFFFFFF; SHR 0x80000000 shamt 40 -> 0x00000000 with out_zero 1.
REQ-032 SHALL cover backpressure: out_ready 0 for 5 cycles while 3 operands are offered -> 2 accepted, then in_ready 0; after out_ready rises, results emerge in order and none are lost.
REQ-033 SHALL cover rotate: ROL 0x80000001 shamt 1 -> 0x00000003 with SHIFT_PIPE_ROTATE_EN, and 0x00000002 without it; ROL shamt 33 with the macro -> same as shamt 1.
REQ-034 SHALL cover reset mid-flight: rst pulsed with 2 transactions in flight -> out_valid 0 immediately, in_ready 1 after release, and no result emitted for the flushed transactions.
REQ-035 SHALL cover back-to-back streaming: 8 consecutive accepts with out_ready held 1 -> 8 results on 8 consecutive cycles starting 2 cycles after the first accept.
